// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing and hazard control for the 3-stage core (fetch, IF_ID, ID_EXE).
// Owns both pipeline valid bits, stalls on load-use, squashes on taken branch, drains on HALT.
module pipeline_ctrl #(
    parameter int RFW          = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int SCW          = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [RFW-1:0] id_rs1,
    input  logic [RFW-1:0] id_rs2,
    input  logic           id_use_rs1,
    input  logic           id_use_rs2,
    input  logic           id_halt,
    input  logic [RFW-1:0] ex_rd,
    input  logic           ex_is_load,
    input  logic           ex_br_taken,
    output logic           pc_clr,
    output logic           pc_en,
    output logic           pc_sel_br,
    output logic           if_id_en,
    output logic           if_id_valid,
    output logic           id_exe_valid,
    output logic           busy,
    output logic           done,
    output logic [SCW-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t         state, state_next;
    logic [3:0]     drain_cnt, drain_next;
    logic           if_id_valid_next, id_exe_valid_next, done_next;
    logic [SCW-1:0] stall_next;
    logic           branch_hit, halt_hit, load_use;
    logic           rs1_match, rs2_match;

    assign rs1_match  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match  = id_use_rs2 && (id_rs2 == ex_rd);
    assign branch_hit = id_exe_valid && ex_br_taken;
    assign halt_hit   = if_id_valid && id_halt;
    // r0 is hard-wired zero, so a load targeting it can never feed a stale value
    assign load_use   = id_exe_valid && ex_is_load && if_id_valid &&
                        (ex_rd != '0) && (rs1_match || rs2_match);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next        = state;
        drain_next        = drain_cnt;
        if_id_valid_next  = if_id_valid;
        id_exe_valid_next = id_exe_valid;
        stall_next        = stall_cnt;
        done_next         = 1'b0;
        pc_clr            = 1'b0;
        pc_en             = 1'b0;
        pc_sel_br         = 1'b0;
        if_id_en          = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                pc_clr            = 1'b1;
                if_id_valid_next  = 1'b0;
                id_exe_valid_next = 1'b0;
                stall_next        = '0;
                state_next        = RUN;
            end
            RUN: begin
                if (branch_hit) begin
                    pc_en             = 1'b1;
                    pc_sel_br         = 1'b1;
                    if_id_en          = 1'b1;
                    if_id_valid_next  = 1'b0;
                    id_exe_valid_next = 1'b0;
                end else if (halt_hit) begin
                    if_id_valid_next  = 1'b0;
                    id_exe_valid_next = 1'b0;
                    drain_next        = 4'(DRAIN_CYCLES);
                    state_next        = DRAIN;
                end else if (load_use) begin
                    id_exe_valid_next = 1'b0;
                    if (stall_cnt != {SCW{1'b1}})
                        stall_next = stall_cnt + {{(SCW-1){1'b0}}, 1'b1};
                end else begin
                    pc_en             = 1'b1;
                    if_id_en          = 1'b1;
                    if_id_valid_next  = 1'b1;
                    id_exe_valid_next = if_id_valid;
                end
            end
            DRAIN: begin
                if_id_valid_next  = 1'b0;
                id_exe_valid_next = 1'b0;
                drain_next        = drain_cnt - 4'd1;
                if (drain_cnt <= 4'd1) begin
                    drain_next = 4'd0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            drain_cnt    <= 4'd0;
            if_id_valid  <= 1'b0;
            id_exe_valid <= 1'b0;
            stall_cnt    <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            drain_cnt    <= drain_next;
            if_id_valid  <= if_id_valid_next;
            id_exe_valid <= id_exe_valid_next;
            stall_cnt    <= stall_next;
            done         <= done_next;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven hazard vectors through a scoreboard queue, plus hand-written
// sequences for start timing, drain/done, asynchronous reset and stall-counter saturation.
module tb_pipeline_ctrl;

    localparam int RFW   = 5;
    localparam int DC    = 3;
    localparam int SCW   = 16;
    localparam int SCW_S = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [RFW-1:0] id_rs1, id_rs2, ex_rd;
    logic           id_use_rs1, id_use_rs2, id_halt, ex_is_load, ex_br_taken;

    logic           pc_clr, pc_en, pc_sel_br, if_id_en, if_id_valid, id_exe_valid, busy, done;
    logic [SCW-1:0] stall_cnt;

    logic             pc_clr_s, pc_en_s, pc_sel_br_s, if_id_en_s, if_id_valid_s, id_exe_valid_s;
    logic             busy_s, done_s;
    logic [SCW_S-1:0] stall_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl #(.RFW(RFW), .DRAIN_CYCLES(DC), .SCW(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt(id_halt), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .pc_clr(pc_clr), .pc_en(pc_en), .pc_sel_br(pc_sel_br), .if_id_en(if_id_en),
        .if_id_valid(if_id_valid), .id_exe_valid(id_exe_valid), .busy(busy), .done(done),
        .stall_cnt(stall_cnt)
    );

    // narrow stall counter so saturation is reachable in a few dozen cycles
    pipeline_ctrl #(.RFW(RFW), .DRAIN_CYCLES(DC), .SCW(SCW_S)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt(id_halt), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .pc_clr(pc_clr_s), .pc_en(pc_en_s), .pc_sel_br(pc_sel_br_s), .if_id_en(if_id_en_s),
        .if_id_valid(if_id_valid_s), .id_exe_valid(id_exe_valid_s), .busy(busy_s), .done(done_s),
        .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [RFW-1:0] rs1, rs2, rd;
        logic           use1, use2, halt, is_load, br;
        logic           e_pc_en, e_sel_br, e_if_id_en, e_ifv, e_exv, e_next_pc_en;
        int             e_stall;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input string n, input int rs1, input int rs2, input int rd,
                                input bit u1, input bit u2, input bit h, input bit ld, input bit br,
                                input bit pe, input bit sb_, input bit ie, input bit iv, input bit ev,
                                input bit npe, input int st);
        vec_t v;
        v.name = n; v.rs1 = RFW'(rs1); v.rs2 = RFW'(rs2); v.rd = RFW'(rd);
        v.use1 = u1; v.use2 = u2; v.halt = h; v.is_load = ld; v.br = br;
        v.e_pc_en = pe; v.e_sel_br = sb_; v.e_if_id_en = ie; v.e_ifv = iv; v.e_exv = ev;
        v.e_next_pc_en = npe; v.e_stall = st;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic neutral();
        start = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_halt = 1'b0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_use_rs1 = v.use1; id_use_rs2 = v.use2; id_halt = v.halt;
        ex_is_load = v.is_load; ex_br_taken = v.br;
        sb.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_load_use();
        neutral(); ex_rd = 5'd3; ex_is_load = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd3;
    endtask

    // reset, start, then run until both pipeline registers hold live instructions
    task automatic prime();
        neutral();
        rst_n = 1'b0; #3; rst_n = 1'b1;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t cur;
        neutral();
        rst_n = 1'b1;

        vecs.push_back(mk("normal",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk("lu_rs2",        0, 3, 3, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk("lu_rs1",        7, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk("lu_r0",         0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk("lu_unused",     5, 0, 5, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk("nonload",       0, 3, 3, 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk("lu_nomatch",    5, 6, 4, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk("branch",        0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk("halt",          0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("br_halt_lu",    0, 3, 3, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk("halt_lu",       0, 3, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset values and start-to-first-instruction timing
        #2 rst_n = 1'b0;
        #2;
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.pc_clr", pc_clr, 1'b0);
        checkOutput("rst.pc_en", pc_en, 1'b0);
        checkOutput("rst.if_id_valid", if_id_valid, 1'b0);
        checkOutput("rst.id_exe_valid", id_exe_valid, 1'b0);
        checkOutput("rst.stall_cnt", stall_cnt, 0);
        checkOutput("rst.done", done, 1'b0);
        tick(); rst_n = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        checkOutput("clr.pc_clr", pc_clr, 1'b1);
        checkOutput("clr.busy", busy, 1'b1);
        checkOutput("clr.pc_en", pc_en, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("run0.pc_clr", pc_clr, 1'b0);
        checkOutput("run0.pc_en", pc_en, 1'b1);
        checkOutput("run0.if_id_valid", if_id_valid, 1'b0);
        tick();
        checkOutput("run1.if_id_valid", if_id_valid, 1'b1);
        checkOutput("run1.id_exe_valid", id_exe_valid, 1'b0);
        tick();
        checkOutput("run2.id_exe_valid", id_exe_valid, 1'b1);
        checkOutput("run2.stall_cnt", stall_cnt, 0);

        // table-driven single-cycle hazard vectors from a primed RUN state
        foreach (vecs[i]) begin
            prime();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                checkOutput({cur.name, ".pc_en"}, pc_en, cur.e_pc_en);
                checkOutput({cur.name, ".pc_sel_br"}, pc_sel_br, cur.e_sel_br);
                checkOutput({cur.name, ".if_id_en"}, if_id_en, cur.e_if_id_en);
                checkOutput({cur.name, ".pc_clr"}, pc_clr, 1'b0);
                tick();
                neutral();
                checkOutput({cur.name, ".if_id_valid"}, if_id_valid, cur.e_ifv);
                checkOutput({cur.name, ".id_exe_valid"}, id_exe_valid, cur.e_exv);
                checkOutput({cur.name, ".stall_cnt"}, stall_cnt, cur.e_stall);
                @(negedge clk);
                checkOutput({cur.name, ".next_pc_en"}, pc_en, cur.e_next_pc_en);
                checkOutput({cur.name, ".next_busy"}, busy, 1'b1);
            end
        end

        // HALT at cycle H: busy through H+3, done only in H+4, restart accepted in H+4
        prime();
        id_halt = 1'b1;
        tick(); neutral();
        for (int k = 1; k <= DC; k++) begin
            @(negedge clk);
            checkOutput($sformatf("drain%0d.busy", k), busy, 1'b1);
            checkOutput($sformatf("drain%0d.done", k), done, 1'b0);
            tick();
        end
        start = 1'b1;
        @(negedge clk);
        checkOutput("halt_end.busy", busy, 1'b0);
        checkOutput("halt_end.done", done, 1'b1);
        tick(); start = 1'b0;
        checkOutput("restart.pc_clr", pc_clr, 1'b1);
        checkOutput("restart.done", done, 1'b0);

        // asynchronous reset in the middle of DRAIN
        prime();
        drive_load_use();
        tick(); neutral();
        id_halt = 1'b1;
        tick(); neutral();
        #2;
        checkOutput("pre_rst_drain.busy", busy, 1'b1);
        checkOutput("pre_rst_drain.stall_cnt", stall_cnt, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_drain.busy", busy, 1'b0);
        checkOutput("rst_drain.stall_cnt", stall_cnt, 0);
        checkOutput("rst_drain.pc_en", pc_en, 1'b0);
        checkOutput("rst_drain.done", done, 1'b0);
        rst_n = 1'b1;

        // asynchronous reset in the middle of a load-use stall
        prime();
        drive_load_use();
        tick(); neutral();
        tick();
        drive_load_use();
        #2;
        checkOutput("pre_rst_stall.pc_en", pc_en, 1'b0);
        checkOutput("pre_rst_stall.if_id_valid", if_id_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_stall.if_id_valid", if_id_valid, 1'b0);
        checkOutput("rst_stall.id_exe_valid", id_exe_valid, 1'b0);
        checkOutput("rst_stall.stall_cnt", stall_cnt, 0);
        checkOutput("rst_stall.busy", busy, 1'b0);
        checkOutput("rst_stall.if_id_en", if_id_en, 1'b0);
        rst_n = 1'b1;
        neutral();

        // repeated stalls: wide counter counts, narrow counter saturates at all-ones
        prime();
        for (int n = 1; n <= 20; n++) begin
            drive_load_use();
            tick(); neutral();
            checkOutput($sformatf("sat%0d.stall_cnt", n), stall_cnt, n);
            checkOutput($sformatf("sat%0d.stall_cnt_s", n), stall_cnt_s, (n > 15) ? 15 : n);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
